// File: rtl/d_mem_arbiter.sv
// Two-master round-robin arbiter in front of the data-memory CPU port, one transaction in flight.
// Optional bus locking is compiled in with `define D_MEM_ARB_LOCK_EN.

module d_mem_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDRESS_BITS = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [ADDRESS_BITS-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   output logic                    m0_gnt,
   output logic                    m0_rvalid,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [ADDRESS_BITS-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   output logic                    m1_gnt,
   output logic                    m1_rvalid,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_in_data,
   input  logic [DATA_WIDTH-1:0]   mem_out_data,
`ifdef D_MEM_ARB_LOCK_EN
   input  logic                    m0_lock,
   input  logic                    m1_lock,
`endif
   output logic                    owner
);

   localparam int unsigned CntW = $clog2(READ_LATENCY + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(READ_LATENCY);

   typedef enum logic {StIdle, StRdWait} state_t;

   state_t                  state_q, state_d;
   logic [CntW-1:0]         lat_cnt_q, lat_cnt_d;
   logic                    last_grant_q, last_grant_d;
   logic                    owner_q, owner_d;
   logic [ADDRESS_BITS-1:0] rd_addr_q, rd_addr_d;

   logic                    req0_eff, req1_eff;
   logic                    winner;
   logic                    win_we;
   logic [ADDRESS_BITS-1:0] win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;

`ifdef D_MEM_ARB_LOCK_EN
   logic lock_q, lock_d;
   logic owner_lock, lock_hold, win_lock;

   assign owner_lock = owner_q ? m1_lock : m0_lock;
   // Lock stays held only while the owner keeps asserting it.
   assign lock_hold  = lock_q & owner_lock;
   assign req0_eff   = m0_req & ~(lock_hold & owner_q);
   assign req1_eff   = m1_req & ~(lock_hold & ~owner_q);
   assign win_lock   = winner ? m1_lock : m0_lock;
`else
   assign req0_eff = m0_req;
   assign req1_eff = m1_req;
`endif

   // On a tie the master that did not win last time takes the bus.
   assign winner    = (req0_eff & req1_eff) ? ~last_grant_q : req1_eff;
   assign win_we    = winner ? m1_we : m0_we;
   assign win_addr  = winner ? m1_addr : m0_addr;
   assign win_wdata = winner ? m1_wdata : m0_wdata;
   assign owner     = owner_q;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      rd_addr_d    = rd_addr_q;
`ifdef D_MEM_ARB_LOCK_EN
      lock_d       = lock_q;
`endif
      m0_gnt       = 1'b0;
      m1_gnt       = 1'b0;
      m0_rvalid    = 1'b0;
      m1_rvalid    = 1'b0;
      m0_rdata     = '0;
      m1_rdata     = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_address  = '0;
      mem_in_data  = '0;

      unique case (state_q)
         StIdle: begin
            if (req0_eff | req1_eff) begin
               m0_gnt      = ~winner;
               m1_gnt      = winner;
               mem_address = win_addr;
               mem_in_data = win_wdata;
               mem_write   = win_we;
               mem_read    = ~win_we;
               owner_d     = winner;
`ifdef D_MEM_ARB_LOCK_EN
               last_grant_d = lock_hold ? last_grant_q : winner;
               lock_d       = win_lock;
`else
               last_grant_d = winner;
`endif
               if (!win_we) begin
                  rd_addr_d = win_addr;
                  lat_cnt_d = CntW'(1);
                  state_d   = StRdWait;
               end
            end else begin
`ifdef D_MEM_ARB_LOCK_EN
               lock_d = lock_hold;
`endif
            end
         end
         StRdWait: begin
            mem_read    = 1'b1;
            mem_address = rd_addr_q;
            if (lat_cnt_q == CntMax) begin
               m0_rvalid = ~owner_q;
               m1_rvalid = owner_q;
               m0_rdata  = owner_q ? '0 : mem_out_data;
               m1_rdata  = owner_q ? mem_out_data : '0;
               lat_cnt_d = '0;
               state_d   = StIdle;
`ifdef D_MEM_ARB_LOCK_EN
               lock_d    = owner_lock;
`endif
            end else begin
               lat_cnt_d = lat_cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are forced low the moment reset asserts, without waiting for a clock.
      if (!reset) begin
         m0_gnt      = 1'b0;
         m1_gnt      = 1'b0;
         m0_rvalid   = 1'b0;
         m1_rvalid   = 1'b0;
         m0_rdata    = '0;
         m1_rdata    = '0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         mem_address = '0;
         mem_in_data = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         lat_cnt_q    <= '0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         rd_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         rd_addr_q    <= rd_addr_d;
      end
   end

`ifdef D_MEM_ARB_LOCK_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`endif

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: directed vectors plus randomized traffic on two instances
// (READ_LATENCY 1 and 3) checked against a transaction-timestamp reference model.

module tb_d_mem_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        m0_req [2], m1_req [2], m0_we [2], m1_we [2];
   logic [31:0] m0_addr [2], m1_addr [2], m0_wdata [2], m1_wdata [2], mem_out_data [2];
   logic        m0_gnt [2], m1_gnt [2], m0_rvalid [2], m1_rvalid [2];
   logic [31:0] m0_rdata [2], m1_rdata [2], mem_address [2], mem_in_data [2];
   logic        mem_read [2], mem_write [2], owner [2];
`ifdef D_MEM_ARB_LOCK_EN
   logic        m0_lock [2], m1_lock [2];
`endif

   d_mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .READ_LATENCY(1)) dut_lat1 (
      .clock(clock), .reset(reset),
      .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
      .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
      .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
      .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
      .mem_in_data(mem_in_data[0]), .mem_out_data(mem_out_data[0]),
`ifdef D_MEM_ARB_LOCK_EN
      .m0_lock(m0_lock[0]), .m1_lock(m1_lock[0]),
`endif
      .owner(owner[0])
   );

   d_mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .READ_LATENCY(3)) dut_lat3 (
      .clock(clock), .reset(reset),
      .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
      .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
      .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
      .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
      .mem_in_data(mem_in_data[1]), .mem_out_data(mem_out_data[1]),
`ifdef D_MEM_ARB_LOCK_EN
      .m0_lock(m0_lock[1]), .m1_lock(m1_lock[1]),
`endif
      .owner(owner[1])
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [159:0] pack(input logic g0, g1, v0, v1, mrd, mwr, own,
                                         input logic [31:0] rd0, rd1, ma, mw);
      return {25'd0, g0, g1, v0, v1, mrd, mwr, own, rd0, rd1, ma, mw};
   endfunction

   function automatic logic [159:0] outs(input int k);
      return pack(m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_read[k], mem_write[k],
                  owner[k], m0_rdata[k], m1_rdata[k], mem_address[k], mem_in_data[k]);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Reference model: a read granted at cycle t delivers data at t+LAT; bus is free after that.
   int          t;
   bit          mbusy [2];
   int          mrv [2];
   bit          mlast [2];
   bit          mown [2];
   logic [31:0] mraddr [2];
   bit          pend0 [2], pend1 [2];

   task automatic clear_inputs(input int k);
      m0_req[k] = 0; m1_req[k] = 0; m0_we[k] = 0; m1_we[k] = 0;
      m0_addr[k] = 0; m1_addr[k] = 0; m0_wdata[k] = 0; m1_wdata[k] = 0;
      mem_out_data[k] = 0;
`ifdef D_MEM_ARB_LOCK_EN
      m0_lock[k] = 0; m1_lock[k] = 0;
`endif
      pend0[k] = 0; pend1[k] = 0;
      mbusy[k] = 0; mlast[k] = 1; mown[k] = 0; mrv[k] = 0; mraddr[k] = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      for (int k = 0; k < 2; k++) clear_inputs(k);
      t = 0;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1;
   endtask

   task automatic model_eval(input int k, output logic [159:0] exp, output logic g0,
                             output logic g1);
      logic v0, v1, mrd, mwr;
      logic [31:0] rd0, rd1, ma, mw;
      v0 = 0; v1 = 0; mrd = 0; mwr = 0; rd0 = 0; rd1 = 0; ma = 0; mw = 0;
      g0 = 0; g1 = 0;
      if (mbusy[k]) begin
         mrd = 1;
         ma  = mraddr[k];
         if (t == mrv[k]) begin
            if (mown[k]) begin v1 = 1; rd1 = mem_out_data[k]; end
            else begin v0 = 1; rd0 = mem_out_data[k]; end
         end
      end else begin
         if (m0_req[k] && m1_req[k]) begin
            if (mlast[k]) g0 = 1; else g1 = 1;
         end else if (m0_req[k]) begin
            g0 = 1;
         end else if (m1_req[k]) begin
            g1 = 1;
         end
         if (g0) begin ma = m0_addr[k]; mw = m0_wdata[k]; mwr = m0_we[k]; mrd = !m0_we[k]; end
         if (g1) begin ma = m1_addr[k]; mw = m1_wdata[k]; mwr = m1_we[k]; mrd = !m1_we[k]; end
      end
      exp = pack(g0, g1, v0, v1, mrd, mwr, mown[k], rd0, rd1, ma, mw);
   endtask

   task automatic model_step(input int k, input logic g0, input logic g1);
      if (mbusy[k]) begin
         if (t == mrv[k]) mbusy[k] = 0;
      end else if (g0 || g1) begin
         mlast[k] = g1;
         mown[k]  = g1;
         if (!(g1 ? m1_we[k] : m0_we[k])) begin
            mbusy[k]  = 1;
            mrv[k]    = t + lat_of(k);
            mraddr[k] = g1 ? m1_addr[k] : m0_addr[k];
         end
      end
   endtask

   task automatic stim(input int k);
      if (pend0[k]) begin
         if ($urandom_range(9) == 0) begin pend0[k] = 0; m0_req[k] = 0; end
      end else if ($urandom_range(1) == 1) begin
         pend0[k] = 1; m0_req[k] = 1; m0_we[k] = 1'($urandom_range(1));
         m0_addr[k] = $urandom; m0_wdata[k] = $urandom;
      end else begin
         m0_req[k] = 0;
      end
      if (pend1[k]) begin
         if ($urandom_range(9) == 0) begin pend1[k] = 0; m1_req[k] = 0; end
      end else if ($urandom_range(1) == 1) begin
         pend1[k] = 1; m1_req[k] = 1; m1_we[k] = 1'($urandom_range(1));
         m1_addr[k] = $urandom; m1_wdata[k] = $urandom;
      end else begin
         m1_req[k] = 0;
      end
      mem_out_data[k] = $urandom;
   endtask

   typedef struct {
      logic r0, r1, w0, w1;
      logic [31:0] a0, a1, d0, d1, md;
      logic g0, g1, v0, v1, mrd, mwr, own;
      logic [31:0] rd0, rd1, ma, mw;
   } vec_t;

   vec_t tbl [8];
   logic [3:0] e3 [6];
   logic [4:0] e4 [5];
   logic [159:0] exp_b;
   logic gs0 [2], gs1 [2];

   initial begin
      tbl[0] = '{H, H, H, H, 32'h9000_0000, 32'h20, 32'h5, 32'hA, 32'h0,
                 H, L, L, L, L, H, L, 32'h0, 32'h0, 32'h9000_0000, 32'h5};
      tbl[1] = '{L, H, L, H, 32'h0, 32'h20, 32'h0, 32'hA, 32'h0,
                 L, H, L, L, L, H, L, 32'h0, 32'h0, 32'h20, 32'hA};
      tbl[2] = '{L, L, L, L, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 L, L, L, L, L, L, H, 32'h0, 32'h0, 32'h0, 32'h0};
      tbl[3] = '{H, L, L, L, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF,
                 H, L, L, L, H, L, H, 32'h0, 32'h0, 32'h10, 32'h0};
      tbl[4] = '{L, L, L, L, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF,
                 L, L, H, L, H, L, L, 32'hDEAD_BEEF, 32'h0, 32'h10, 32'h0};
      tbl[5] = '{L, H, L, L, 32'h0, 32'h44, 32'h0, 32'h77, 32'h1234,
                 L, H, L, L, H, L, L, 32'h0, 32'h0, 32'h44, 32'h77};
      tbl[6] = '{L, L, L, L, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234,
                 L, L, L, H, H, L, H, 32'h0, 32'h1234, 32'h44, 32'h0};
      tbl[7] = '{L, L, L, L, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5555,
                 L, L, L, L, L, L, H, 32'h0, 32'h0, 32'h0, 32'h0};
      e3 = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
      e4 = '{5'b01010, 5'b00010, 5'b00010, 5'b00110, 5'b10001};

      // Reset values, checked while reset is held with requests pending.
      for (int k = 0; k < 2; k++) clear_inputs(k);
      m0_req[0] = 1; m1_req[1] = 1;
      #2 check("reset_state_lat1", outs(0), '0);
      check("reset_state_lat3", outs(1), '0);

      // Directed vectors on the latency-1 instance.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         m0_req[0] = tbl[i].r0; m1_req[0] = tbl[i].r1; m0_we[0] = tbl[i].w0;
         m1_we[0] = tbl[i].w1; m0_addr[0] = tbl[i].a0; m1_addr[0] = tbl[i].a1;
         m0_wdata[0] = tbl[i].d0; m1_wdata[0] = tbl[i].d1; mem_out_data[0] = tbl[i].md;
         @(negedge clock);
         check($sformatf("vec%0d", i), outs(0),
               pack(tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].mrd, tbl[i].mwr,
                    tbl[i].own, tbl[i].rd0, tbl[i].rd1, tbl[i].ma, tbl[i].mw));
         @(posedge clock);
         #1;
      end

      // Both masters reading continuously, latency 1.
      do_reset();
      m0_req[0] = 1; m0_addr[0] = 32'h100; m1_req[0] = 1; m1_addr[0] = 32'h200;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         check($sformatf("rr_read_c%0d", c),
               {m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0]}, e3[c]);
         @(posedge clock);
         #1;
      end

      // Latency-3 read by M1; M0 write waits until the bus frees.
      do_reset();
      m1_req[1] = 1; m1_addr[1] = 32'h9000_0010; mem_out_data[1] = 32'hCAFE_0003;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            m1_req[1] = 0; m0_req[1] = 1; m0_we[1] = 1; m0_addr[1] = 32'h30;
         end
         @(negedge clock);
         check($sformatf("lat3_c%0d", c),
               {m0_gnt[1], m1_gnt[1], m1_rvalid[1], mem_read[1], mem_write[1]}, e4[c]);
         if (c == 2) check("lat3_hold_addr", mem_address[1], 32'h9000_0010);
         if (c == 3) check("lat3_rdata", m1_rdata[1], 32'hCAFE_0003);
         @(posedge clock);
         #1;
      end

      // Reset in the middle of a latency-3 read.
      do_reset();
      m1_req[1] = 1; m1_addr[1] = 32'h9000_0010; mem_out_data[1] = 32'h1111_2222;
      m0_req[0] = 1; m0_we[0] = 1;
      @(negedge clock);
      check("rst_mid_gnt", m1_gnt[1], 1'b1);
      @(posedge clock);
      #1 reset = 0;
      #1 check("rst_mid_async_lat3", outs(1), '0);
      check("rst_mid_async_lat1", outs(0), '0);
      repeat (4) @(posedge clock);
      #1 reset = 1;
      m0_req[1] = 1; m0_we[1] = 1; m1_req[1] = 1; m1_we[1] = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (c == 0) check("rst_release_m0_first", {m0_gnt[1], m1_gnt[1]}, 2'b10);
         check($sformatf("rst_no_rvalid_c%0d", c), {m0_rvalid[1], m1_rvalid[1]}, 2'b00);
         @(posedge clock);
         #1;
      end

`ifdef D_MEM_ARB_LOCK_EN
      do_reset();
      m0_req[0] = 1; m0_we[0] = 1; m1_req[0] = 1; m1_we[0] = 1; m0_lock[0] = 1;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) m0_lock[0] = 0;
         @(negedge clock);
         check($sformatf("lock_c%0d", c), {m0_gnt[0], m1_gnt[0]}, (c == 3) ? 2'b01 : 2'b10);
         @(posedge clock);
         #1;
      end
`endif

      // Randomized traffic on both instances against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) stim(k);
         @(negedge clock);
         for (int k = 0; k < 2; k++) begin
            model_eval(k, exp_b, gs0[k], gs1[k]);
            check($sformatf("rand_lat%0d_n%0d", lat_of(k), n), outs(k), exp_b);
         end
         @(posedge clock);
         for (int k = 0; k < 2; k++) begin
            model_step(k, gs0[k], gs1[k]);
            if (gs0[k]) pend0[k] = 0;
            if (gs1[k]) pend1[k] = 0;
         end
         t++;
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
